// File: rtl/vga_sync_receiver.sv
// Recovers pixel column/line from an hsync/vsync/video_on stream and tracks timing lock
// against the nominal line and frame lengths, flagging loss of lock.
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int HD          = 640,
    parameter int VD          = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_valid,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_error,
    output logic [9:0] h_meas,
    output logic [9:0] v_meas
);
    localparam logic [9:0] LP_H_TOTAL = 10'(H_TOTAL);
    localparam logic [9:0] LP_V_TOTAL = 10'(V_TOTAL);
    localparam logic [9:0] LP_HD      = 10'(HD);
    localparam logic [9:0] LP_VD      = 10'(VD);
    localparam logic [9:0] LP_MAX     = 10'd1023;
    localparam logic [2:0] LP_LOCK    = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_good;
    logic [2:0] w_good_next;

    logic       r_hs_d;
    logic       r_vs_d;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [9:0] r_h_meas;
    logic [9:0] r_v_meas;
    logic       r_pixel_valid;
    logic       r_frame_start;
    logic       r_sync_error;

    logic       w_hs_fall;
    logic       w_vs_fall;
    logic       w_frame_end;
    logic       w_line_bad;
    logic       w_frame_bad;
    logic       w_misalign;
    logic       w_x_sat;
    logic [9:0] w_x_inc;
    logic [9:0] w_y_inc;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_fs_next;
    logic       w_se_next;
    logic       w_pv_next;

    assign w_hs_fall   = r_hs_d & ~hsync;
    assign w_vs_fall   = r_vs_d & ~vsync;
    assign w_frame_end = w_hs_fall & w_vs_fall;
    assign w_misalign  = w_vs_fall & ~w_hs_fall;

    assign w_x_inc = (r_x == LP_MAX) ? LP_MAX : r_x + 10'd1;
    assign w_y_inc = (r_y == LP_MAX) ? LP_MAX : r_y + 10'd1;

    // The incremented value doubles as the just-finished line/frame length.
    assign w_line_bad  = w_hs_fall & (w_x_inc != LP_H_TOTAL);
    assign w_frame_bad = w_frame_end & (w_y_inc != LP_V_TOTAL);
    assign w_x_sat     = ~w_hs_fall & (w_x_inc == LP_MAX);

    assign w_x_next = w_hs_fall ? 10'd0 : w_x_inc;
    assign w_y_next = w_hs_fall ? (w_vs_fall ? 10'd0 : w_y_inc) : r_y;

    // A bad line leaves ACQUIRE at once, so a frame reaching its end had no bad line.
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        w_fs_next    = 1'b0;
        w_se_next    = 1'b0;
        if (p_tick) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_frame_end) begin
                        w_state_next = ST_ACQUIRE;
                        w_good_next  = 3'd0;
                    end
                end
                ST_ACQUIRE: begin
                    if (w_line_bad || w_misalign || w_frame_bad) begin
                        w_state_next = ST_SEARCH;
                    end else if (w_frame_end) begin
                        w_good_next = r_good + 3'd1;
                        if (r_good + 3'd1 == LP_LOCK) begin
                            w_state_next = ST_LOCKED;
                            w_fs_next    = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_line_bad || w_misalign || w_frame_bad || w_x_sat) begin
                        w_state_next = ST_SEARCH;
                        w_se_next    = 1'b1;
                    end else if (w_frame_end) begin
                        w_fs_next = 1'b1;
                    end
                end
                default: w_state_next = ST_SEARCH;
            endcase
        end
    end

    assign w_pv_next = (w_state_next == ST_LOCKED) & video_on &
                       (w_x_next < LP_HD) & (w_y_next < LP_VD);

    always_ff @(posedge clk_100Mhz) begin
        if (!reset) begin
            r_state <= ST_SEARCH;
            r_good  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_good  <= w_good_next;
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (!reset) begin
            r_hs_d        <= 1'b0;
            r_vs_d        <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_h_meas      <= 10'd0;
            r_v_meas      <= 10'd0;
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_error  <= 1'b0;
        end else begin
            r_frame_start <= w_fs_next;
            r_sync_error  <= w_se_next;
            if (p_tick) begin
                r_hs_d        <= hsync;
                r_vs_d        <= vsync;
                r_x           <= w_x_next;
                r_y           <= w_y_next;
                r_pixel_valid <= w_pv_next;
                if (w_hs_fall) begin
                    r_h_meas <= w_x_inc;
                end
                if (w_frame_end) begin
                    r_v_meas <= w_y_inc;
                end
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign h_meas      = r_h_meas;
    assign v_meas      = r_v_meas;
    assign pixel_valid = r_pixel_valid;
    assign locked      = (r_state == ST_LOCKED);
    assign frame_start = r_frame_start;
    assign sync_error  = r_sync_error;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: a small-raster source, a tick-index reference model checked
// every clock, and literal expectations for lock, error, reset and pause scenarios.
module tb_vga_sync_receiver;
    localparam int H   = 40;
    localparam int V   = 12;
    localparam int HDP = 32;
    localparam int VDP = 10;
    localparam int HSW = 4;
    localparam int VSW = 2;
    localparam int LF  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p_tick = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] x;
    logic [9:0] y;
    logic       pixel_valid;
    logic       locked;
    logic       frame_start;
    logic       sync_error;
    logic [9:0] h_meas;
    logic [9:0] v_meas;

    vga_sync_receiver #(
        .H_TOTAL(H), .V_TOTAL(V), .HD(HDP), .VD(VDP), .LOCK_FRAMES(LF)
    ) dut (
        .clk_100Mhz(clk), .reset(reset), .p_tick(p_tick),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .x(x), .y(y), .pixel_valid(pixel_valid), .locked(locked),
        .frame_start(frame_start), .sync_error(sync_error),
        .h_meas(h_meas), .v_meas(v_meas)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    int fs_seen = 0;
    int se_seen = 0;
    bit pin_en = 0;

    // Reference model: positions are derived from absolute tick/line indices of the last sync events.
    int m_n = 0, m_ls = 0, m_L = 0, m_fsl = 0;
    int m_mode = 0, m_good = 0;
    bit m_phs = 0, m_pvs = 0;
    int m_x = 0, m_y = 0, m_h = 0, m_v = 0, m_pv = 0, m_fs = 0, m_se = 0;

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clk(input bit rst_n, input bit tk, input bit hs, input bit vs, input bit vo);
        bit hf, vf, frame_end, line_bad, frame_bad, mis, x_over;
        m_fs = 0;
        m_se = 0;
        if (!rst_n) begin
            m_mode = 0; m_good = 0; m_phs = 0; m_pvs = 0;
            m_ls = m_n; m_fsl = m_L;
            m_x = 0; m_y = 0; m_h = 0; m_v = 0; m_pv = 0;
        end else if (tk) begin
            m_n++;
            hf = m_phs && !hs;
            vf = m_pvs && !vs;
            m_phs = hs;
            m_pvs = vs;
            line_bad = 0; frame_end = 0; frame_bad = 0;
            if (hf) begin
                m_h = sat(m_n - m_ls);
                m_ls = m_n;
                line_bad = (m_h != H);
                if (vf) begin
                    m_v = sat(m_L + 1 - m_fsl);
                    frame_end = 1;
                    frame_bad = (m_v != V);
                    m_fsl = m_L + 1;
                end
                m_L++;
            end
            m_x = sat(m_n - m_ls);
            m_y = sat(m_L - m_fsl);
            mis = vf && !hf;
            x_over = (m_x == 1023);
            case (m_mode)
                0: if (hf && vf) begin m_mode = 1; m_good = 0; end
                1: begin
                    if (line_bad || mis || frame_bad) m_mode = 0;
                    else if (frame_end) begin
                        m_good++;
                        if (m_good == LF) begin m_mode = 2; m_fs = 1; end
                    end
                end
                default: begin
                    if (line_bad || mis || frame_bad || x_over) begin m_mode = 0; m_se = 1; end
                    else if (frame_end) m_fs = 1;
                end
            endcase
            m_pv = (m_mode == 2 && vo && m_x < HDP && m_y < VDP) ? 1 : 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("x", {22'd0, x}, m_x);
            chk("y", {22'd0, y}, m_y);
            chk("h_meas", {22'd0, h_meas}, m_h);
            chk("v_meas", {22'd0, v_meas}, m_v);
            chk("locked", {31'd0, locked}, (m_mode == 2) ? 1 : 0);
            chk("pixel_valid", {31'd0, pixel_valid}, m_pv);
            chk("frame_start", {31'd0, frame_start}, m_fs);
            chk("sync_error", {31'd0, sync_error}, m_se);
            if (frame_start) fs_seen++;
            if (sync_error) se_seen++;
        end
    end

    task automatic cyc(input bit tk);
        p_tick = tk;
        @(posedge clk);
        model_clk(reset, tk, hsync, vsync, video_on);
        #1;
    endtask

    task automatic src_tick(input bit hs, input bit vs, input bit vo);
        hsync = hs; vsync = vs; video_on = vo;
        cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_x"}, {22'd0, x}, 0);
        chk({nm, "_y"}, {22'd0, y}, 0);
        chk({nm, "_h"}, {22'd0, h_meas}, 0);
        chk({nm, "_v"}, {22'd0, v_meas}, 0);
        chk({nm, "_locked"}, {31'd0, locked}, 0);
        chk({nm, "_pv"}, {31'd0, pixel_valid}, 0);
        chk({nm, "_fs"}, {31'd0, frame_start}, 0);
        chk({nm, "_se"}, {31'd0, sync_error}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1'b0);
        reset = 1'b1;
        chk_all_zero("midreset");
    endtask

    task automatic do_pause(input int hc, input int vc);
        fs_seen = 0;
        se_seen = 0;
        for (int i = 0; i < 50; i++) cyc(1'b0);
        chk("pause_x", {22'd0, x}, hc - 1);
        chk("pause_y", {22'd0, y}, vc);
        chk("pause_locked", {31'd0, locked}, 1);
        chk("pause_fs_cnt", fs_seen, 0);
        chk("pause_se_cnt", se_seen, 0);
    endtask

    task automatic pin(input int hc, input int vc);
        int pv;
        pv = -1;
        if (hc == 0 && vc == 0) pv = 1;
        if (hc == HDP - 1 && vc == VDP - 1) pv = 1;
        if (hc == HDP && vc == 0) pv = 0;
        if (hc == 0 && vc == VDP) pv = 0;
        if (pin_en && pv >= 0) begin
            chk("pin_x", {22'd0, x}, hc);
            chk("pin_y", {22'd0, y}, vc);
            chk("pin_pv", {31'd0, pixel_valid}, pv);
        end
    endtask

    // hook_kind: 1 = one-clock reset before tick hook_hc, 2 = 50-clock p_tick pause before it.
    task automatic send_line(input int len, input int vc, input int hook_hc, input int hook_kind);
        for (int hc = 0; hc < len; hc++) begin
            if (hc == hook_hc && hook_kind == 1) do_reset();
            if (hc == hook_hc && hook_kind == 2) do_pause(hc, vc);
            src_tick(hc >= len - HSW, vc >= V - VSW, hc < HDP && vc < VDP);
            pin(hc, vc);
        end
    endtask

    task automatic send_frame(input int short_vc, input int hook_vc, input int hook_hc, input int kind);
        for (int vc = 0; vc < V; vc++)
            send_line((vc == short_vc) ? H - 1 : H, vc, (vc == hook_vc) ? hook_hc : -1, kind);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) send_frame(-1, -1, -1, 0);
    endtask

    task automatic relock(input string nm);
        frames(2);
        chk({nm, "_not_yet"}, {31'd0, locked}, 0);
        frames(1);
        chk({nm, "_relocked"}, {31'd0, locked}, 1);
    endtask

    initial begin
        cyc(1'b0);
        chk_en = 1;
        cyc(1'b0);
        reset = 1'b1;
        chk_all_zero("reset");

        // First frame has no preceding sync edge; lock lands at the start of the fourth.
        frames(3);
        chk("lock_early", {31'd0, locked}, 0);
        fs_seen = 0;
        pin_en = 1;
        frames(1);
        chk("lock", {31'd0, locked}, 1);
        chk("lock_h_meas", {22'd0, h_meas}, H);
        chk("lock_v_meas", {22'd0, v_meas}, V);
        chk("fs_cnt_entry", fs_seen, 1);
        fs_seen = 0;
        frames(1);
        chk("fs_cnt_frame", fs_seen, 1);
        pin_en = 0;

        se_seen = 0;
        send_frame(5, -1, -1, 0);
        chk("short_se_cnt", se_seen, 1);
        chk("short_locked", {31'd0, locked}, 0);
        relock("short");

        for (int vc = 0; vc < 3; vc++) send_line(H, vc, -1, 0);
        se_seen = 0;
        for (int i = 0; i < 1100; i++) src_tick(1'b0, 1'b0, 1'b0);
        chk("hold_x_sat", {22'd0, x}, 1023);
        chk("hold_se_cnt", se_seen, 1);
        chk("hold_locked", {31'd0, locked}, 0);
        frames(1);
        relock("hold");

        se_seen = 0;
        send_frame(-1, 3, 10, 1);
        chk("reset_se_cnt", se_seen, 0);
        relock("reset");

        send_frame(-1, 4, 7, 2);
        chk("pause_end_locked", {31'd0, locked}, 1);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning pixel ticks per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-003 SHALL have parameter HD, default 640, meaning active pixels per line.
REQ-004 SHALL have parameter VD, default 480, meaning active lines per frame.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, range 1-7, meaning consecutive good frames required to lock.
REQ-006 SHALL have port clk_100Mhz  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port p_tick  input  1  pixel enable; input sampling and counters advance only when p_tick=1.
REQ-009 SHALL have ports hsync, vsync  input  1 each  active-high sync pulses.
REQ-010 SHALL have port video_on  input  1  active-area indication from the source.
REQ-011 SHALL have ports x, y  output  10 each  recovered pixel column and line.
REQ-012 SHALL have port pixel_valid  output  1  recovered pixel is inside the active area while locked.
REQ-013 SHALL have port locked  output  1  timing lock status.
REQ-014 SHALL have port frame_start  output  1  one-clock pulse at recovered pixel (0,0).
REQ-015 SHALL have port sync_error  output  1  one-clock pulse on loss of lock.
REQ-016 SHALL have ports h_meas, v_meas  output  10 each  last measured line length (ticks) and frame length (lines).

Function
REQ-017 SHALL register hsync, vsync and video_on into delayed copies only on clocks with p_tick=1; edges are defined as delayed=1, current=0 (falling) at such a clock.
REQ-018 SHALL treat an hsync falling edge as pixel x=0 of a new line; x SHALL become 0 on that clock and otherwise increment by 1 per p_tick, saturating at 1023.
REQ-019 SHALL, on an hsync falling edge, load h_meas with the previous x value +1 (saturated at 1023) and increment y, except when vsync also falls on the same tick, in which case y SHALL become 0.
REQ-020 SHALL, on a vsync falling edge that does not coincide with an hsync falling edge, flag a misaligned frame and treat it as a mismatch.
REQ-021 SHALL load v_meas with the previous y value +1 when y is reset to 0; y saturates at 1023.
REQ-022 SHALL implement a state machine: SEARCH, ACQUIRE, LOCKED.
REQ-023 SEARCH: wait for coincident hsync/vsync falling edge, then go to ACQUIRE with good-frame count 0.
REQ-024 ACQUIRE: each line end checks h_meas==H_TOTAL; each frame end checks v_meas==V_TOTAL and no line mismatch in the frame; a good frame increments the count, and LOCKED is entered when it reaches LOCK_FRAMES; any mismatch returns to SEARCH without sync_error.
REQ-025 LOCKED: any line-length mismatch, frame-length mismatch, misaligned vsync, or x reaching 1023 SHALL pulse sync_error for one clock and return to SEARCH.
REQ-026 locked SHALL be 1 exactly while the state is LOCKED.
REQ-027 frame_start SHALL pulse for one clock when y is set to 0 while in LOCKED, or on the LOCKED entry frame.
REQ-028 pixel_valid SHALL be locked AND sampled video_on AND x<HD AND y<VD, registered with x and y.
REQ-029 All outputs SHALL be registered; outputs reflect the tick sampled on the same clock edge (latency 1 clock from input to output).
REQ-030 Clocks with p_tick=0 SHALL hold all state and outputs, except frame_start and sync_error, which SHALL be 0.

Reset
REQ-031 While reset=0 at a clock edge: state=SEARCH; x=0, y=0, h_meas=0, v_meas=0; locked, pixel_valid, frame_start, sync_error=0; delayed copies of hsync, vsync and video_on=0.
REQ-032 Reset asserted mid-frame SHALL abandon lock immediately with no sync_error pulse; reacquisition restarts from SEARCH.

Verification
REQ-033 Nominal 800x525 source, p_tick every 4th clock -> locked=1 after the second full frame; h_meas=800, v_meas=525.
REQ-034 Locked, one line shortened to 799 ticks -> single sync_error pulse, locked=0, state SEARCH, relock after 2 good frames.
REQ-035 Locked, pixel (0,0) -> frame_start pulses once per frame; pixel_valid=1 at (0,0) and (639,479), 0 at (640,0) and (0,480).
REQ-036 Locked, hsync held low for 1100 ticks -> x saturates at 1023, sync_error pulses once, locked=0.
REQ-037 reset=0 for one clock mid-line while locked -> all outputs 0 next clock, no sync_error pulse, relock after 2 frames.
REQ-038 p_tick held 0 for 50 clocks mid-line -> x, y and state unchanged; frame_start and sync_error remain 0.
